// File: rtl/mem_copy_master.sv
// Word-copy initiator: reads `length` words from src and writes them to dst over one memory port.
// Latency: 2 + read wait + write wait cycles per word (4 cycles per word with a unit-latency port).
// Backpressure: one transaction in flight; each WAIT state holds until m_ready or the timeout expires.
module mem_copy_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int LEN_WIDTH  = 8,
  parameter int TIMEOUT    = 15
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] src_addr,
  input  logic [ADDR_WIDTH-1:0] dst_addr,
  input  logic [LEN_WIDTH-1:0]  length,
  output logic                  busy,
  output logic                  done,
  output logic                  error,
  output logic [LEN_WIDTH-1:0]  count,
  output logic [ADDR_WIDTH-1:0] m_addr,
  output logic [31:0]           m_din,
  output logic [3:0]            m_wr,
  output logic                  m_enable,
  input  logic [31:0]           m_dout,
  input  logic                  m_ready
);

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_RD_REQ  = 3'd1;
  localparam logic [2:0] ST_RD_WAIT = 3'd2;
  localparam logic [2:0] ST_WR_REQ  = 3'd3;
  localparam logic [2:0] ST_WR_WAIT = 3'd4;

  localparam int               WAIT_W    = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT - 1);

  logic [2:0]            state_q,  state_d;
  logic [ADDR_WIDTH-1:0] src_q,    src_d;
  logic [ADDR_WIDTH-1:0] dst_q,    dst_d;
  logic [LEN_WIDTH-1:0]  len_q,    len_d;
  logic [31:0]           data_q,   data_d;
  logic [WAIT_W-1:0]     wait_q,   wait_d;
  logic [LEN_WIDTH-1:0]  count_q,  count_d;
  logic                  error_q,  error_d;
  logic                  done_q,   done_d;
  logic                  busy_q,   busy_d;
  logic [ADDR_WIDTH-1:0] m_addr_q, m_addr_d;
  logic [31:0]           m_din_q,  m_din_d;
  logic [3:0]            m_wr_q,   m_wr_d;
  logic                  m_en_q,   m_en_d;

  logic [LEN_WIDTH-1:0]  count_inc;
  logic                  wait_expired;

  assign count_inc    = count_q + LEN_WIDTH'(1);
  assign wait_expired = (wait_q == WAIT_LAST);

  // Next-state logic; port outputs are derived from the next state so they register Moore-style.
  always_comb begin
    state_d = state_q;
    src_d   = src_q;
    dst_d   = dst_q;
    len_d   = len_q;
    data_d  = data_q;
    wait_d  = wait_q;
    count_d = count_q;
    error_d = error_q;
    done_d  = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          src_d   = src_addr;
          dst_d   = dst_addr;
          len_d   = length;
          count_d = '0;
          error_d = 1'b0;
          if (length == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = ST_RD_REQ;
          end
        end
      end
      ST_RD_REQ: begin
        state_d = ST_RD_WAIT;
        wait_d  = '0;
      end
      ST_RD_WAIT: begin
        if (m_ready) begin
          data_d  = m_dout;
          state_d = ST_WR_REQ;
        end else if (wait_expired) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      ST_WR_REQ: begin
        state_d = ST_WR_WAIT;
        wait_d  = '0;
      end
      ST_WR_WAIT: begin
        if (m_ready) begin
          // Response data on a write is an echo and is deliberately dropped.
          count_d = count_inc;
          src_d   = src_q + ADDR_WIDTH'(1);
          dst_d   = dst_q + ADDR_WIDTH'(1);
          if (count_inc == len_q) begin
            state_d = ST_IDLE;
            done_d  = 1'b1;
          end else begin
            state_d = ST_RD_REQ;
          end
        end else if (wait_expired) begin
          state_d = ST_IDLE;
          error_d = 1'b1;
          done_d  = 1'b1;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d   = (state_d != ST_IDLE);
    m_en_d   = (state_d == ST_RD_REQ) || (state_d == ST_WR_REQ);
    m_wr_d   = (state_d == ST_WR_REQ) ? 4'hF : 4'h0;
    m_addr_d = '0;
    m_din_d  = '0;
    if (state_d == ST_RD_REQ) begin
      m_addr_d = src_d;
    end else if (state_d == ST_WR_REQ) begin
      m_addr_d = dst_d;
      m_din_d  = data_d;
    end
  end

  // State and output registers; reset aborts any transfer with every output forced low.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      src_q    <= '0;
      dst_q    <= '0;
      len_q    <= '0;
      data_q   <= '0;
      wait_q   <= '0;
      count_q  <= '0;
      error_q  <= 1'b0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
      m_addr_q <= '0;
      m_din_q  <= '0;
      m_wr_q   <= 4'h0;
      m_en_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      src_q    <= src_d;
      dst_q    <= dst_d;
      len_q    <= len_d;
      data_q   <= data_d;
      wait_q   <= wait_d;
      count_q  <= count_d;
      error_q  <= error_d;
      done_q   <= done_d;
      busy_q   <= busy_d;
      m_addr_q <= m_addr_d;
      m_din_q  <= m_din_d;
      m_wr_q   <= m_wr_d;
      m_en_q   <= m_en_d;
    end
  end

  assign busy     = busy_q;
  assign done     = done_q;
  assign error    = error_q;
  assign count    = count_q;
  assign m_addr   = m_addr_q;
  assign m_din    = m_din_q;
  assign m_wr     = m_wr_q;
  assign m_enable = m_en_q;

endmodule

// File: tb/tb_mem_copy_master.sv
// Bench for mem_copy_master: behavioural memory port with per-request latency and fault injection.
// Expected data and timing come from an ascending-copy model and the per-request latencies issued.
// The port model never stalls except where a scenario deliberately withholds m_ready.
module tb_mem_copy_master;

  localparam int TO = 15;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic [7:0]  src_addr;
  logic [7:0]  dst_addr;
  logic [7:0]  length;
  logic        busy;
  logic        done;
  logic        error;
  logic [7:0]  count;
  logic [7:0]  m_addr;
  logic [31:0] m_din;
  logic [3:0]  m_wr;
  logic        m_enable;
  logic [31:0] m_dout;
  logic        m_ready;

  int checks;
  int failures;
  int cyc;

  logic [31:0] mem     [256];
  logic [31:0] exp_mem [256];

  // Port-model state (owned by the responder process).
  int          en_cnt;
  int          viol;
  int          req_idx;
  logic [7:0]  rd_q[$];
  logic [7:0]  wr_q[$];
  int          lat_q[$];
  // Port-model controls (owned by the test sequence).
  int          lat_min;
  int          lat_max;
  int          drop_idx;
  int          spur_idx;

  mem_copy_master #(.ADDR_WIDTH(8), .LEN_WIDTH(8), .TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst_n), .start(start), .src_addr(src_addr), .dst_addr(dst_addr),
    .length(length), .busy(busy), .done(done), .error(error), .count(count),
    .m_addr(m_addr), .m_din(m_din), .m_wr(m_wr), .m_enable(m_enable),
    .m_dout(m_dout), .m_ready(m_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Memory port model: sees requests at the falling edge, answers k cycles later.
  initial begin : responder
    int          pend;
    bit          prev_en;
    bit          p_wr;
    logic [7:0]  p_addr;
    logic [31:0] p_din;
    int          k;
    pend = 0; prev_en = 1'b0; p_wr = 1'b0; p_addr = '0; p_din = '0;
    en_cnt = 0; viol = 0; req_idx = 0;
    m_ready = 1'b0;
    m_dout  = '0;
    forever begin
      @(negedge clk);
      m_ready = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          m_ready = 1'b1;
          m_dout  = p_wr ? p_din : mem[p_addr];
        end
      end
      if (rst_n && m_enable) begin
        en_cnt++;
        if (prev_en) viol++;
        if (m_wr != 4'h0 && m_wr != 4'hF) viol++;
        p_addr = m_addr;
        p_wr   = (m_wr != 4'h0);
        p_din  = m_din;
        if (p_wr) begin
          mem[m_addr] = m_din;
          wr_q.push_back(m_addr);
        end else begin
          rd_q.push_back(m_addr);
          if (req_idx == spur_idx) begin
            m_ready = 1'b1;
            m_dout  = 32'hDEAD_BEEF;
          end
        end
        if (req_idx >= drop_idx) begin
          pend = 0;
        end else begin
          k = $urandom_range(lat_max, lat_min);
          lat_q.push_back(k);
          pend = k;
        end
        req_idx++;
      end else if (m_wr != 4'h0) begin
        viol++;
      end
      prev_en = m_enable;
    end
  end

  task automatic do_copy(input logic [7:0] s, input logic [7:0] d, input logic [7:0] n,
                         input bit hold, output int done_rel, output int busy_n);
    int t0;
    done_rel = -1;
    busy_n   = 0;
    @(negedge clk);
    src_addr = s; dst_addr = d; length = n; start = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!hold) start = 1'b0;
      if (busy) busy_n++;
      if (done) begin
        done_rel = cyc - t0;
        break;
      end
    end
    start = 1'b0;
  endtask

  task automatic fill_random();
    for (int i = 0; i < 256; i++) mem[i] = $urandom;
  endtask

  task automatic model_copy(input logic [7:0] s, input logic [7:0] d, input int n);
    logic [7:0] sp, dp;
    for (int i = 0; i < 256; i++) exp_mem[i] = mem[i];
    sp = s; dp = d;
    for (int i = 0; i < n; i++) begin
      exp_mem[dp] = exp_mem[sp];
      sp = sp + 8'd1;
      dp = dp + 8'd1;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; src_addr = '0; dst_addr = '0; length = '0;
    lat_min = 1; lat_max = 1; drop_idx = 32'h7FFF_FFFF; spur_idx = -1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error} !== 3'b000) begin
      failures++; $display("FAIL reset_flags got=%b want=000", {busy, done, error});
    end
    checks++;
    if (count !== 8'd0) begin failures++; $display("FAIL reset_count got=%0d want=0", count); end
    checks++;
    if ({m_addr, m_din} !== 40'd0) begin
      failures++; $display("FAIL reset_addr_din got=%h want=0", {m_addr, m_din});
    end
    checks++;
    if ({m_wr, m_enable} !== 5'd0) begin
      failures++; $display("FAIL reset_wr_en got=%b want=0", {m_wr, m_enable});
    end
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if ({busy, done, error, m_enable, m_wr} !== 8'd0) begin
      failures++; $display("FAIL idle_after_reset got=%b want=0", {busy, done, error, m_enable, m_wr});
    end
  endtask

  task automatic test_basic();
    int dr, bn, e0, v0;
    logic [31:0] want [4];
    fill_random();
    want[0] = 32'h1111_1111; want[1] = 32'h2222_2222;
    want[2] = 32'h3333_3333; want[3] = 32'h4444_4444;
    for (int i = 0; i < 4; i++) mem[8'h10 + i] = want[i];
    lat_min = 1; lat_max = 1;
    e0 = en_cnt; v0 = viol;
    do_copy(8'h10, 8'h80, 8'd4, 1'b0, dr, bn);
    checks++;
    if (dr !== 17) begin failures++; $display("FAIL basic_done_cycle got=%0d want=17", dr); end
    checks++;
    if (count !== 8'd4 || error !== 1'b0) begin
      failures++; $display("FAIL basic_count_err got=%0d/%b want=4/0", count, error);
    end
    checks++;
    if (en_cnt - e0 !== 8) begin failures++; $display("FAIL basic_enables got=%0d want=8", en_cnt - e0); end
    checks++;
    if (bn !== 16) begin failures++; $display("FAIL basic_busy_cycles got=%0d want=16", bn); end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8'h80 + i] !== want[i]) begin
        failures++; $display("FAIL basic_word%0d got=%h want=%h", i, mem[8'h80 + i], want[i]);
      end
    end
    checks++;
    if (viol - v0 !== 0) begin failures++; $display("FAIL basic_protocol got=%0d want=0", viol - v0); end
  endtask

  task automatic test_zero_len();
    int dr, bn, e0, extra;
    e0 = en_cnt;
    do_copy(8'h33, 8'h44, 8'd0, 1'b0, dr, bn);
    extra = 0;
    repeat (5) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (dr !== 1) begin failures++; $display("FAIL zero_done_cycle got=%0d want=1", dr); end
    checks++;
    if (bn !== 0 || extra !== 0) begin
      failures++; $display("FAIL zero_busy got=%0d/%0d want=0/0", bn, extra);
    end
    checks++;
    if (en_cnt - e0 !== 0) begin failures++; $display("FAIL zero_port got=%0d want=0", en_cnt - e0); end
  endtask

  task automatic test_wrap();
    int dr, bn, rb, wb, bad_r, bad_w;
    logic [7:0] er [4];
    fill_random();
    er[0] = 8'hFE; er[1] = 8'hFF; er[2] = 8'h00; er[3] = 8'h01;
    model_copy(8'hFE, 8'h02, 4);
    rb = rd_q.size(); wb = wr_q.size();
    do_copy(8'hFE, 8'h02, 8'd4, 1'b0, dr, bn);
    bad_r = (rd_q.size() - rb != 4) ? 1 : 0;
    bad_w = (wr_q.size() - wb != 4) ? 1 : 0;
    if (bad_r == 0) for (int i = 0; i < 4; i++) if (rd_q[rb + i] !== er[i]) bad_r++;
    if (bad_w == 0) for (int i = 0; i < 4; i++) if (wr_q[wb + i] !== 8'(8'h02 + i)) bad_w++;
    checks++;
    if (bad_r !== 0) begin failures++; $display("FAIL wrap_read_order bad=%0d want=0", bad_r); end
    checks++;
    if (bad_w !== 0) begin failures++; $display("FAIL wrap_write_order bad=%0d want=0", bad_w); end
    checks++;
    if (dr !== 17 || error !== 1'b0) begin
      failures++; $display("FAIL wrap_done got=%0d/%b want=17/0", dr, error);
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (mem[8'(8'h02 + i)] !== exp_mem[8'(8'h02 + i)]) begin
        failures++; $display("FAIL wrap_word%0d got=%h want=%h", i, mem[8'(8'h02 + i)], exp_mem[8'(8'h02 + i)]);
      end
    end
  endtask

  task automatic test_timeout();
    int dr, bn;
    logic [31:0] w;
    fill_random();
    lat_min = 1; lat_max = 1;
    drop_idx = req_idx + 2;
    do_copy(8'h50, 8'hC0, 8'd3, 1'b0, dr, bn);
    checks++;
    if (dr !== 5 + TO + 1) begin failures++; $display("FAIL timeout_done_cycle got=%0d want=%0d", dr, 5 + TO + 1); end
    checks++;
    if (error !== 1'b1 || count !== 8'd1) begin
      failures++; $display("FAIL timeout_err_count got=%b/%0d want=1/1", error, count);
    end
    checks++;
    if (bn !== 5 + TO) begin failures++; $display("FAIL timeout_busy got=%0d want=%0d", bn, 5 + TO); end
    drop_idx = 32'h7FFF_FFFF;
    repeat (3) @(negedge clk);
    checks++;
    if (error !== 1'b1 || done !== 1'b0) begin
      failures++; $display("FAIL timeout_sticky got=%b/%b want=1/0", error, done);
    end
    w = mem[8'h60];
    do_copy(8'h60, 8'hD0, 8'd1, 1'b0, dr, bn);
    checks++;
    if (dr !== 5 || error !== 1'b0 || count !== 8'd1) begin
      failures++; $display("FAIL timeout_recover got=%0d/%b/%0d want=5/0/1", dr, error, count);
    end
    checks++;
    if (mem[8'hD0] !== w) begin failures++; $display("FAIL timeout_recover_data got=%h want=%h", mem[8'hD0], w); end
  endtask

  task automatic test_ignored();
    int dr, bn, e0, extra;
    fill_random();
    model_copy(8'h20, 8'h21, 2);
    lat_min = 1; lat_max = 1;
    spur_idx = req_idx;
    e0 = en_cnt;
    do_copy(8'h20, 8'h21, 8'd2, 1'b1, dr, bn);
    spur_idx = -1;
    extra = 0;
    repeat (10) begin
      @(negedge clk);
      if (done || busy) extra++;
    end
    checks++;
    if (dr !== 9 || count !== 8'd2) begin
      failures++; $display("FAIL ignored_timing got=%0d/%0d want=9/2", dr, count);
    end
    checks++;
    if (en_cnt - e0 !== 4 || extra !== 0) begin
      failures++; $display("FAIL ignored_single got=%0d/%0d want=4/0", en_cnt - e0, extra);
    end
    checks++;
    if (mem[8'h21] !== exp_mem[8'h21] || mem[8'h22] !== exp_mem[8'h22]) begin
      failures++; $display("FAIL ignored_data got=%h,%h want=%h,%h", mem[8'h21], mem[8'h22], exp_mem[8'h21], exp_mem[8'h22]);
    end
  endtask

  task automatic test_reset_mid();
    int t0, dr, bn, dseen;
    logic [31:0] w;
    fill_random();
    lat_min = 1; lat_max = 1;
    @(negedge clk);
    src_addr = 8'h30; dst_addr = 8'h90; length = 8'd3; start = 1'b1;
    t0 = cyc;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    checks++;
    if (cyc - t0 !== 8 || busy !== 1'b1 || count !== 8'd1) begin
      failures++; $display("FAIL midrst_pre got=%0d/%b/%0d want=8/1/1", cyc - t0, busy, count);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({busy, done, error, count, m_addr, m_din, m_wr, m_enable} !== 56'd0) begin
      failures++; $display("FAIL midrst_outputs got=%h want=0", {busy, done, error, count, m_addr, m_din, m_wr, m_enable});
    end
    dseen = 0;
    repeat (3) begin
      @(negedge clk);
      if (done) dseen++;
    end
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      if (done) dseen++;
    end
    checks++;
    if (dseen !== 0) begin failures++; $display("FAIL midrst_no_done got=%0d want=0", dseen); end
    w = mem[8'h40];
    do_copy(8'h40, 8'hA0, 8'd1, 1'b0, dr, bn);
    checks++;
    if (dr !== 5 || mem[8'hA0] !== w || count !== 8'd1) begin
      failures++; $display("FAIL midrst_restart got=%0d/%h/%0d want=5/%h/1", dr, mem[8'hA0], count, w);
    end
  endtask

  task automatic test_random();
    int dr, bn, lb, rb, v0, want_done, bad_mem, bad_rd, n;
    logic [7:0] s, d;
    for (int it = 0; it < 8; it++) begin
      fill_random();
      s = 8'($urandom); d = 8'($urandom);
      n = $urandom_range(12, 1);
      lat_min = 1;
      lat_max = (it % 2 == 0) ? TO : $urandom_range(TO, 1);
      model_copy(s, d, n);
      lb = lat_q.size(); rb = rd_q.size(); v0 = viol;
      do_copy(s, d, 8'(n), 1'b0, dr, bn);
      want_done = 1;
      for (int i = lb; i < lat_q.size(); i++) want_done += 1 + lat_q[i];
      bad_mem = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== exp_mem[i]) bad_mem++;
      bad_rd = (rd_q.size() - rb != n) ? 1 : 0;
      if (bad_rd == 0) for (int i = 0; i < n; i++) if (rd_q[rb + i] !== 8'(s + i)) bad_rd++;
      checks++;
      if (dr !== want_done || lat_q.size() - lb !== 2 * n) begin
        failures++; $display("FAIL rand%0d_done got=%0d want=%0d reqs=%0d", it, dr, want_done, lat_q.size() - lb);
      end
      checks++;
      if (count !== 8'(n) || error !== 1'b0 || bn !== want_done - 1) begin
        failures++; $display("FAIL rand%0d_status got=%0d/%b/%0d want=%0d/0/%0d", it, count, error, bn, n, want_done - 1);
      end
      checks++;
      if (bad_mem !== 0 || bad_rd !== 0) begin
        failures++; $display("FAIL rand%0d_data mem_bad=%0d rd_bad=%0d want=0/0", it, bad_mem, bad_rd);
      end
      checks++;
      if (viol - v0 !== 0) begin failures++; $display("FAIL rand%0d_protocol got=%0d want=0", it, viol - v0); end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_basic();
    test_zero_len();
    test_wrap();
    test_timeout();
    test_ignored();
    test_reset_mid();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mem_copy_master.md
# mem_copy_master

Single-channel word-copy initiator for the simulation memory-port protocol (address, data-in, 4-bit byte write strobe, enable, data-out, ready). On a start command it reads `length` 32-bit words from a source address and writes them to a destination address through one memory port, one transaction outstanding at a time. It sits on the bench side of a memory port and preloads or relocates test images without CPU involvement. A ready-timeout flags a non-responding port.

## Interface
- `ADDR_WIDTH`, default 8: word-address width; must match the memory port.
- `LEN_WIDTH`, default 8: width of the word-count fields.
- `TIMEOUT`, default 15: maximum wait cycles for `m_ready` per transaction; must be at least 1.

- `clk`  in  1  single clock; all logic is on the rising edge.
- `rst`  in  1  reset, asynchronous, active-low (0 = reset).
- `start`  in  1  start request; sampled only in IDLE.
- `src_addr`  in  ADDR_WIDTH  first source word address; latched on start.
- `dst_addr`  in  ADDR_WIDTH  first destination word address; latched on start.
- `length`  in  LEN_WIDTH  number of words to copy; latched on start.
- `busy`  out  1  transfer in progress.
- `done`  out  1  one-cycle completion pulse, for success or error.
- `error`  out  1  sticky timeout flag; cleared by the next accepted start.
- `count`  out  LEN_WIDTH  words fully written in the current or last transfer.
- `m_addr`  out  ADDR_WIDTH  port address.
- `m_din`  out  32  port write data.
- `m_wr`  out  4  byte write strobe; 4'hF on writes, 4'h0 otherwise.
- `m_enable`  out  1  transaction valid.
- `m_dout`  in  32  port read data; valid when `m_ready` is 1.
- `m_ready`  in  1  port response strobe.

## Operation
- All outputs are registered, Moore-style. Reset drives every output to 0 and the FSM to IDLE.
- FSM states are IDLE, RD_REQ, RD_WAIT, WR_REQ and WR_WAIT.
- **IDLE**
  - If `start`=1: latch `src_addr`, `dst_addr` and `length`; clear `count` and `error`.
  - If `length`=0: pulse `done` next cycle, keep `busy`=0, drive no port traffic.
  - Otherwise go to RD_REQ with `busy`=1.
- **RD_REQ** (exactly 1 cycle): `m_enable`=1, `m_wr`=0, `m_addr`=src pointer. Go to RD_WAIT.
- **RD_WAIT**: `m_enable`=0. On `m_ready`=1, capture `m_dout` into the data register and go to WR_REQ.
- **WR_REQ** (exactly 1 cycle): `m_enable`=1, `m_wr`=4'hF, `m_addr`=dst pointer, `m_din`=data register. Go to WR_WAIT.
- **WR_WAIT**: `m_enable`=0, `m_wr`=0. On `m_ready`=1:
  - increment `count` and both pointers;
  - if `count`+1 equals `length`, go to IDLE, drop `busy` and pulse `done`;
  - otherwise go to RD_REQ.
- `m_wr` is 0 in every state except WR_REQ. The port echoes `m_din` whenever `m_wr`≠0, so a nonzero strobe outside WR_REQ is a bug.
- `m_dout` is ignored on write responses.
- Pointers wrap modulo 2^ADDR_WIDTH; the wrap is not an error. Overlapping source and destination ranges are copied in ascending order with no overlap protection.
- **Timeout**
  - The wait counter clears on entering RD_WAIT or WR_WAIT and increments on each wait cycle with `m_ready`=0.
  - After TIMEOUT consecutive such cycles: go to IDLE, set `error`=1, pulse `done`, drop `busy`. `count` holds the words completed.
- `start` while busy is ignored. `m_ready` outside the WAIT states is ignored.
- An asynchronous reset mid-transfer aborts immediately: outputs go to 0, no `done` pulse, and any partially issued write may or may not land in memory.

## Timing
- Cycle 0 is `start` sampled in IDLE. Cycle 1 is RD_REQ for word 0.
- With a 1-cycle-latency responder, each word takes 4 cycles: RD_REQ, RD_WAIT, WR_REQ, WR_WAIT.
- For `length`=N≥1: `busy` is high in cycles 1 to 4N, and `done` is high in cycle 4N+1 with `busy`=0. A new start can be sampled in cycle 4N+1.
- For `length`=0: `done` is high in cycle 1, with no `m_enable` pulses.
- A response arriving k cycles after the request stretches the WAIT state to k cycles, for 1 ≤ k ≤ TIMEOUT.
- On timeout, `done` and `error` rise TIMEOUT+1 cycles after the last request cycle.
- `m_enable` is never high in two consecutive cycles.

## Test plan
- **Basic copy.** Memory holds 0x11111111 to 0x44444444 at 0x10 to 0x13. Start with src=0x10, dst=0x80, length=4. Required: words appear at 0x80 to 0x83, `done` in cycle 17, `count`=4, `error`=0, exactly 8 `m_enable` pulses.
- **Zero length.** Start with length=0. Required: `done` in cycle 1, `busy` never high, no port activity.
- **Wrap-around.** ADDR_WIDTH=8, src=0xFE, dst=0x02, length=4. Required: reads 0xFE, 0xFF, 0x00, 0x01 in that order; writes to 0x02 through 0x05.
- **Timeout.** Hold `m_ready`=0 after the second read request of a length=3 copy. Required: `done` and `error` set TIMEOUT+1 cycles after that request, `count`=1. A following start with length=1 clears `error` and completes normally.
- **Ignored inputs.** Assert `start` every cycle during a length=2 copy and inject a spurious `m_ready` in RD_REQ. Required: a single transfer, timing identical to the unit-latency case, correct data.
- **Reset mid-transfer.** Pull `rst` low during WR_WAIT of word 1. Required: all outputs 0 asynchronously, no `done`. After release, IDLE accepts a new start.
